// File: rtl/opfb_fir_cfg_hls_deadlock_mon_param_if.sv
// -----------------------------------------------------------------------------
// opfb_fir_cfg_hls_deadlock_mon_param_if
//   Bundles the observation flags and deadlock report of the OPFB FIR config
//   path deadlock monitor.
//   master : the dataflow side. It drives the block, idle and clear flags and
//            reads back the report.
//   slave  : the monitor. It reads the flags and drives the report.
//   Signals
//     axis_block_sigs [N_AXIS] : AXIS channel i stalled this cycle
//     inst_idle_sigs  [N_INST] : sub-instance j idle
//     inst_block_sigs [N_INST] : sub-instance j internal block
//     clear                    : synchronous clear of latched state
//     axis_block_info [N_AXIS] : channels taking part in the detected deadlock
//     block                    : deadlock detected
//     first_axis_idx  [IDX_W]  : lowest blocked channel at BLOCKED entry
//     block_events    [EVT_W]  : saturating count of BLOCKED entries
// -----------------------------------------------------------------------------
interface opfb_fir_cfg_hls_deadlock_mon_param_if #(
  parameter int N_AXIS = 4,
  parameter int N_INST = 2,
  parameter int IDX_W  = 2,
  parameter int EVT_W  = 8
);
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_INST-1:0] inst_block_sigs;
  logic              clear;
  logic [N_AXIS-1:0] axis_block_info;
  logic              block;
  logic [IDX_W-1:0]  first_axis_idx;
  logic [EVT_W-1:0]  block_events;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  axis_block_info, block, first_axis_idx, block_events
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output axis_block_info, block, first_axis_idx, block_events
  );
endinterface

// File: rtl/opfb_fir_cfg_hls_deadlock_mon_param.sv
// -----------------------------------------------------------------------------
// opfb_fir_cfg_hls_deadlock_mon_param
//   Deadlock monitor for an HLS dataflow region. A deadlock candidate is any
//   AXIS or sub-instance block flag while not all sub-instances are idle. It is
//   reported as a deadlock only after it has persisted HOLD_CYCLES cycles.
//   Ports
//     clock   : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : slave modport of opfb_fir_cfg_hls_deadlock_mon_param_if
//               (flags in, block/mask/index/event-count out)
// -----------------------------------------------------------------------------
module opfb_fir_cfg_hls_deadlock_mon_param #(
  parameter int N_AXIS      = 4,
  parameter int N_INST      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8,
  parameter int EVT_W       = 8,
  parameter bit STICKY      = 1'b1,
  parameter int IDX_W       = 2
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  opfb_fir_cfg_hls_deadlock_mon_param_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUSPECT = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_AXIS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [EVT_W-1:0]  evt_q, evt_d;

  logic              cand;
  logic              enter;
  logic [IDX_W-1:0]  low_idx;

  // All-idle sub-instances mean the region finished: block flags are stale then.
  assign cand = (|bus.axis_block_sigs | |bus.inst_block_sigs) & ~(&bus.inst_idle_sigs);

  // Lowest set channel; scanning downwards lets the lowest index win last.
  always_comb begin
    low_idx = '0;
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (bus.axis_block_sigs[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    evt_d      = evt_q;
    enter      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cand) begin
          if (HOLD_CYCLES == 1) begin
            state_d = S_BLOCKED;
            enter   = 1'b1;
          end else begin
            state_d    = S_SUSPECT;
            hold_cnt_d = CNT_W'(1);
          end
        end
      end
      S_SUSPECT: begin
        if (!cand) begin
          state_d    = S_IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_BLOCKED;
          enter   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      S_BLOCKED: begin
        if (STICKY) begin
          mask_d = mask_q | bus.axis_block_sigs;
        end else if (!cand) begin
          state_d    = S_IDLE;
          hold_cnt_d = '0;
        end else begin
          mask_d = bus.axis_block_sigs;
        end
      end
      default: begin
        state_d    = S_IDLE;
        hold_cnt_d = '0;
      end
    endcase

    if (enter) begin
      mask_d = bus.axis_block_sigs;
      idx_d  = low_idx;
      evt_d  = (&evt_q) ? evt_q : evt_q + EVT_W'(1);
    end

    // Clear wins over everything, including a same-cycle BLOCKED entry.
    if (bus.clear) begin
      state_d    = S_IDLE;
      hold_cnt_d = '0;
      mask_d     = '0;
      idx_d      = '0;
      evt_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      evt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      evt_q      <= evt_d;
    end
  end

  // Decoded straight from flops, so reset clears them without a clock edge.
  assign bus.block           = (state_q == S_BLOCKED);
  assign bus.axis_block_info = bus.block ? mask_q : '0;
  assign bus.first_axis_idx  = idx_q;
  assign bus.block_events    = evt_q;

endmodule

// File: tb/tb_opfb_fir_cfg_hls_deadlock_mon_param.sv
// -----------------------------------------------------------------------------
// tb_opfb_fir_cfg_hls_deadlock_mon_param
//   Three monitors share one stimulus stream:
//     inst 0 : defaults (HOLD 16, STICKY 1, EVT_W 8)
//     inst 1 : HOLD 16, STICKY 0, EVT_W 2 (event saturation)
//     inst 2 : HOLD 1,  STICKY 0, EVT_W 8 (minimum hold)
//   The reference model tracks the length of the current run of candidate
//   cycles. A monitor is blocked once that run reaches HOLD, or, when sticky,
//   once it has ever reached HOLD since the last clear.
// -----------------------------------------------------------------------------
module tb_opfb_fir_cfg_hls_deadlock_mon_param;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] sigs;
  logic [1:0] idle;
  logic [1:0] iblk;
  logic       clr;

  always #5 clock = ~clock;

  opfb_fir_cfg_hls_deadlock_mon_param_if #(.N_AXIS(4), .N_INST(2), .IDX_W(2), .EVT_W(8)) if_a ();
  opfb_fir_cfg_hls_deadlock_mon_param_if #(.N_AXIS(4), .N_INST(2), .IDX_W(2), .EVT_W(2)) if_b ();
  opfb_fir_cfg_hls_deadlock_mon_param_if #(.N_AXIS(4), .N_INST(2), .IDX_W(2), .EVT_W(8)) if_c ();

  assign if_a.axis_block_sigs = sigs;
  assign if_a.inst_idle_sigs  = idle;
  assign if_a.inst_block_sigs = iblk;
  assign if_a.clear           = clr;
  assign if_b.axis_block_sigs = sigs;
  assign if_b.inst_idle_sigs  = idle;
  assign if_b.inst_block_sigs = iblk;
  assign if_b.clear           = clr;
  assign if_c.axis_block_sigs = sigs;
  assign if_c.inst_idle_sigs  = idle;
  assign if_c.inst_block_sigs = iblk;
  assign if_c.clear           = clr;

  opfb_fir_cfg_hls_deadlock_mon_param #(
    .N_AXIS(4), .N_INST(2), .HOLD_CYCLES(16), .CNT_W(8), .EVT_W(8), .STICKY(1'b1), .IDX_W(2)
  ) dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a.slave));

  opfb_fir_cfg_hls_deadlock_mon_param #(
    .N_AXIS(4), .N_INST(2), .HOLD_CYCLES(16), .CNT_W(8), .EVT_W(2), .STICKY(1'b0), .IDX_W(2)
  ) dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b.slave));

  opfb_fir_cfg_hls_deadlock_mon_param #(
    .N_AXIS(4), .N_INST(2), .HOLD_CYCLES(1), .CNT_W(8), .EVT_W(8), .STICKY(1'b0), .IDX_W(2)
  ) dut_c (.clock(clock), .reset_n(reset_n), .bus(if_c.slave));

  // ---------------------------------------------------------------- model
  int         p_hold   [3] = '{16, 16, 1};
  bit         p_sticky [3] = '{1'b1, 1'b0, 1'b0};
  int         p_evtmax [3] = '{255, 3, 255};

  int         m_run  [3];
  bit         m_blk  [3];
  logic [3:0] m_mask [3];
  int         m_idx  [3];
  int         m_evt  [3];

  int         n_cmp = 0;
  int         n_err = 0;
  string      phase = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s [%s]: observed %0h expected %0h", tag, phase, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_run[m] = 0; m_blk[m] = 1'b0; m_mask[m] = '0; m_idx[m] = 0; m_evt[m] = 0;
    end
  endtask

  // One rising edge with the inputs currently applied.
  task automatic model_edge();
    bit cand;
    bit nb;
    cand = ((sigs != 0) || (iblk != 0)) && (idle != 2'b11);
    for (int m = 0; m < 3; m++) begin
      if (clr) begin
        m_run[m] = 0; m_blk[m] = 1'b0; m_mask[m] = '0; m_idx[m] = 0; m_evt[m] = 0;
      end else begin
        m_run[m] = cand ? ((m_run[m] < 1000) ? m_run[m] + 1 : m_run[m]) : 0;
        nb = (m_run[m] >= p_hold[m]) || (p_sticky[m] && m_blk[m]);
        if (nb && !m_blk[m]) begin
          m_mask[m] = sigs;
          m_idx[m]  = lowest_set(sigs);
          m_evt[m]  = (m_evt[m] < p_evtmax[m]) ? m_evt[m] + 1 : m_evt[m];
        end else if (nb) begin
          m_mask[m] = p_sticky[m] ? (m_mask[m] | sigs) : sigs;
        end
        m_blk[m] = nb;
      end
    end
  endtask

  task automatic check_inst(input int m, input logic blk, input logic [3:0] info,
                            input logic [1:0] idx, input logic [7:0] evt);
    check($sformatf("u%0d block", m), 32'(blk), 32'(m_blk[m]));
    check($sformatf("u%0d info", m), 32'(info), m_blk[m] ? 32'(m_mask[m]) : 32'd0);
    check($sformatf("u%0d idx", m), 32'(idx), 32'(m_idx[m]));
    check($sformatf("u%0d events", m), 32'(evt), 32'(m_evt[m]));
  endtask

  task automatic check_all();
    check_inst(0, if_a.block, if_a.axis_block_info, if_a.first_axis_idx, if_a.block_events);
    check_inst(1, if_b.block, if_b.axis_block_info, if_b.first_axis_idx, 8'(if_b.block_events));
    check_inst(2, if_c.block, if_c.axis_block_info, if_c.first_axis_idx, if_c.block_events);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input logic [3:0] s, input logic [1:0] id, input logic [1:0] ib,
                      input logic c);
    sigs = s; idle = id; iblk = ib; clr = c;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic run(input int n, input logic [3:0] s, input logic [1:0] id,
                     input logic [1:0] ib);
    for (int k = 0; k < n; k++) step(s, id, ib, 1'b0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n = 1'b0; sigs = '0; idle = '0; iblk = '0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all();
    reset_n = 1'b1;

    phase = "basic";
    run(16, 4'b0100, 2'b00, 2'b00);
    check("u0 block at 16th edge", 32'(if_a.block), 32'd1);
    step(4'b0000, 2'b00, 2'b00, 1'b1);

    phase = "gap";
    run(15, 4'b1000, 2'b00, 2'b00);
    run(1, 4'b0000, 2'b00, 2'b00);
    run(16, 4'b1010, 2'b00, 2'b00);
    check("u0 events after gap", 32'(if_a.block_events), 32'd1);
    step(4'b0000, 2'b00, 2'b00, 1'b1);

    phase = "sticky_accum";
    run(16, 4'b0100, 2'b01, 2'b00);
    run(2, 4'b0001, 2'b01, 2'b00);
    run(3, 4'b0000, 2'b01, 2'b00);
    check("u0 accumulated info", 32'(if_a.axis_block_info), 32'h5);
    step(4'b0000, 2'b00, 2'b00, 1'b1);

    phase = "nonsticky";
    run(16, 4'b0010, 2'b10, 2'b00);
    run(2, 4'b0000, 2'b10, 2'b00);
    run(16, 4'b0010, 2'b10, 2'b00);
    check("u1 events re-block", 32'(if_b.block_events), 32'd2);
    for (int r = 0; r < 3; r++) begin
      run(16, 4'b1100, 2'b00, 2'b00);
      run(1, 4'b0000, 2'b00, 2'b00);
    end
    check("u1 events saturated", 32'(if_b.block_events), 32'd3);
    step(4'b0000, 2'b00, 2'b00, 1'b1);

    phase = "inst_only";
    run(16, 4'b0000, 2'b00, 2'b01);
    check("u0 inst-only idx", 32'(if_a.first_axis_idx), 32'd0);
    step(4'b0000, 2'b00, 2'b00, 1'b1);
    run(20, 4'b0110, 2'b11, 2'b01);

    phase = "clear_vs_entry";
    run(15, 4'b0100, 2'b00, 2'b00);
    step(4'b0100, 2'b00, 2'b00, 1'b1);
    run(3, 4'b0100, 2'b00, 2'b00);

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      logic [3:0] s;
      logic [1:0] id;
      logic [1:0] ib;
      logic       c;
      s  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ib = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      id = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      c  = ($urandom_range(0, 79) == 0);
      step(s, id, ib, c);
    end

    phase = "async_reset";
    step(4'b0000, 2'b00, 2'b00, 1'b1);
    run(16, 4'b1000, 2'b00, 2'b00);
    check("u0 blocked before reset", 32'(if_a.block), 32'd1);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
    run(2, 4'b0000, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
